// File: rtl/ultrasonic_pkg.sv
// Shared types and default timing for the ultrasonic ranging sequencer.
// All timing values are in 1 MHz clock cycles (microseconds).
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    REPORT,
    GAP
  } state_e;

  localparam int unsigned DEF_TRIG_US    = 10;
  localparam int unsigned DEF_RISE_TO_US = 5000;
  localparam int unsigned DEF_ECHO_TO_US = 38000;
  localparam int unsigned DEF_GAP_US     = 60000;

endpackage

// File: rtl/ultrasonic_scan_ctrl_sync_2ff.sv
// Two-flop synchronizer bank; every bit sees the same two-cycle latency.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ultrasonic_scan_ctrl.sv
// Round-robin ultrasonic ranging sequencer: trigger, echo timing and
// valid/ready result reporting for one sensor at a time.
module ultrasonic_scan_ctrl
  import ultrasonic_pkg::*;
#(
  parameter int unsigned N_SENS     = 4,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned TRIG_US    = DEF_TRIG_US,
  parameter int unsigned RISE_TO_US = DEF_RISE_TO_US,
  parameter int unsigned ECHO_TO_US = DEF_ECHO_TO_US,
  parameter int unsigned GAP_US     = DEF_GAP_US,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk_1m,
  input  logic              rst,
  input  logic              en,
  input  logic [N_SENS-1:0] echo,
  output logic [N_SENS-1:0] trig,
  output logic              meas_valid,
  input  logic              meas_ready,
  output logic [ID_W-1:0]   meas_id,
  output logic [CNT_W-1:0]  meas_width,
  output logic              meas_timeout,
  output logic              busy
);

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_US - 1);
  localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_TO_US - 1);
  localparam logic [CNT_W-1:0] ECHO_LIM  = CNT_W'(ECHO_TO_US);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_US - 1);
  localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(N_SENS - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [N_SENS-1:0]   trig_q, trig_d;
  logic [CNT_W-1:0]    width_q, width_d;
  logic                to_q, to_d;
  logic [N_SENS-1:0]   echo_s;
  logic                echo_cur;

  sync_2ff #(
    .WIDTH (N_SENS)
  ) u_echo_sync (
    .clk_i  (clk_1m),
    .rst_ni (rst),
    .d_i    (echo),
    .q_o    (echo_s)
  );

  assign echo_cur = echo_s[id_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    width_d = width_q;
    to_d    = to_q;
    trig_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = TRIG;
          cnt_d   = '0;
        end
      end
      TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_RISE: begin
        // The cycle that sees the rise is the first high cycle, hence count=1.
        if (echo_cur) begin
          state_d = MEASURE;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == RISE_LAST) begin
          state_d = REPORT;
          width_d = '0;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MEASURE: begin
        if (!echo_cur) begin
          state_d = REPORT;
          width_d = cnt_q;
          to_d    = 1'b0;
        end else if (cnt_q == ECHO_LIM) begin
          state_d = REPORT;
          width_d = ECHO_LIM;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REPORT: begin
        if (meas_ready) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          id_d    = (id_q == ID_LAST) ? '0 : id_q + ID_W'(1);
          state_d = en ? TRIG : IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered one-hot trigger decoded from the next state so it is glitch-free.
    if (state_d == TRIG) trig_d[id_d] = 1'b1;
  end

  always_ff @(posedge clk_1m or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      trig_q  <= '0;
      width_q <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      trig_q  <= trig_d;
      width_q <= width_d;
      to_q    <= to_d;
    end
  end

  assign trig         = trig_q;
  assign meas_valid   = (state_q == REPORT);
  assign meas_id      = id_q;
  assign meas_width   = width_q;
  assign meas_timeout = to_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ultrasonic_scan_ctrl.sv
// Randomized scoreboard bench for ultrasonic_scan_ctrl with shortened timing.
module tb_ultrasonic_scan_ctrl;

  localparam int unsigned N     = 4;
  localparam int unsigned IDW   = 2;
  localparam int unsigned TRIGC = 10;
  localparam int unsigned RISE  = 40;
  localparam int unsigned ECHO  = 100;
  localparam int unsigned GAPC  = 25;
  localparam int unsigned CW    = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0;
  logic [N-1:0]   echo = '0;
  logic [N-1:0]   trig;
  logic           meas_valid;
  logic           meas_ready = 1'b1;
  logic [IDW-1:0] meas_id;
  logic [CW-1:0]  meas_width;
  logic           meas_timeout;
  logic           busy;

  ultrasonic_scan_ctrl #(
    .N_SENS     (N),
    .ID_W       (IDW),
    .TRIG_US    (TRIGC),
    .RISE_TO_US (RISE),
    .ECHO_TO_US (ECHO),
    .GAP_US     (GAPC),
    .CNT_W      (CW)
  ) dut (
    .clk_1m       (clk),
    .rst          (rst),
    .en           (en),
    .echo         (echo),
    .trig         (trig),
    .meas_valid   (meas_valid),
    .meas_ready   (meas_ready),
    .meas_id      (meas_id),
    .meas_width   (meas_width),
    .meas_timeout (meas_timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int width;
    bit to;
    bit rise_to;
    int fall_cyc;
  } exp_t;

  exp_t sb[$];
  int   npass = 0;
  int   ntot = 0;
  int   cyc = 0;
  int   n_hs = 0;
  bit   stall_req = 1'b0;
  bit   force_hit = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input longint act, input longint req);
    ntot++;
    if (ok) npass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
  endtask

  // Consumer: random ready, plus one long back-pressure window on request.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_req) begin
        stall_req  = 1'b0;
        meas_ready = 1'b0;
        repeat (300) @(posedge clk);
        #1;
      end else begin
        meas_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor and reference model: sensor order, trigger shape, gap length,
  // echo stimulus generation and result scoreboard.
  initial begin
    logic [N-1:0] prev_trig;
    bit           prev_valid, held_ok, hs_pending, en_low_seen;
    int           exp_id, trig_len, cur_id, hs_cyc, rid, d, w, m;
    bit           none;
    logic [IDW-1:0] h_id;
    logic [CW-1:0]  h_w;
    logic           h_to;
    exp_t         e;
    prev_trig = '0; prev_valid = 0; held_ok = 0; hs_pending = 0; en_low_seen = 0;
    exp_id = 0; trig_len = 0; cur_id = 0; hs_cyc = 0;
    h_id = '0; h_w = '0; h_to = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        sb.delete();
        prev_trig = '0; prev_valid = 0; held_ok = 0; hs_pending = 0;
        exp_id = 0; trig_len = 0;
        continue;
      end
      chk($countones(trig) <= 1, "trig_onehot", trig, 0);
      if (trig != 0 && prev_trig == 0) begin
        rid = 0;
        for (int i = 0; i < N; i++) if (trig[i]) rid = i;
        chk(rid == exp_id, "rr_order", rid, exp_id);
        exp_id   = (rid + 1) % N;
        cur_id   = rid;
        trig_len = 1;
        if (hs_pending && !en_low_seen) chk(cyc - hs_cyc == GAPC + 1, "gap_len", cyc - hs_cyc, GAPC + 1);
        hs_pending = 0;
      end else if (trig != 0) begin
        chk(trig == prev_trig, "trig_hold", trig, prev_trig);
        trig_len++;
      end else if (prev_trig != 0) begin
        chk(trig_len == TRIGC, "trig_len", trig_len, TRIGC);
        none = 0;
        if (force_hit) begin
          force_hit = 0; d = 2; w = 30;
        end else begin
          m = $urandom_range(0, 9);
          if (m == 0) begin
            none = 1; d = 0; w = 0;
          end else if (m == 1) begin
            d = $urandom_range(RISE - 2, RISE); w = $urandom_range(1, 5);
          end else begin
            d = (m == 2) ? RISE - 3 : $urandom_range(0, RISE - 4);
            w = ($urandom_range(0, 3) == 0) ? $urandom_range(ECHO - 1, ECHO + 3)
                                            : $urandom_range(1, ECHO - 2);
          end
        end
        e.id = cur_id; e.fall_cyc = cyc;
        // Two sync flops plus the sampling edge: a rise driven d cycles after
        // the trigger falls is seen d+3 cycles later.
        if (none || d + 3 > RISE) begin
          e.width = 0; e.to = 1; e.rise_to = 1;
        end else if (w > ECHO) begin
          e.width = ECHO; e.to = 1; e.rise_to = 0;
        end else begin
          e.width = w; e.to = 0; e.rise_to = 0;
        end
        sb.push_back(e);
        fork
          begin
            automatic int  fi = cur_id;
            automatic int  fd = d;
            automatic int  fw = w;
            automatic bit  fn = none;
            if (!fn) begin
              repeat (fd) @(posedge clk);
              #1 echo[fi] = 1'b1;
              repeat (fw) @(posedge clk);
              #1 echo[fi] = 1'b0;
            end
          end
        join_none
      end
      if (meas_valid) chk(trig == 0, "trig_in_report", trig, 0);
      if (meas_valid && !prev_valid && sb.size() > 0 && sb[0].rise_to)
        chk(cyc - sb[0].fall_cyc == RISE, "rise_timeout_lat", cyc - sb[0].fall_cyc, RISE);
      if (held_ok) begin
        chk(meas_valid, "stall_valid", meas_valid, 1);
        chk({meas_id, meas_width, meas_timeout} == {h_id, h_w, h_to}, "stall_stable",
            {meas_id, meas_width, meas_timeout}, {h_id, h_w, h_to});
      end
      if (meas_valid && meas_ready) begin
        if (sb.size() == 0) begin
          chk(0, "unexpected_result", meas_id, -1);
        end else begin
          e = sb.pop_front();
          chk(int'(meas_id) == e.id, "meas_id", meas_id, e.id);
          chk(int'(meas_width) == e.width, "meas_width", meas_width, e.width);
          chk(meas_timeout == e.to, "meas_timeout", meas_timeout, e.to);
        end
        n_hs++;
        hs_pending  = 1;
        hs_cyc      = cyc;
        en_low_seen = 0;
      end
      if (!en) en_low_seen = 1;
      held_ok = meas_valid && !meas_ready;
      h_id = meas_id; h_w = meas_width; h_to = meas_timeout;
      prev_trig  = trig;
      prev_valid = meas_valid;
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    $display("%0d/%0d checks passed", npass, ntot);
    $fatal(1, "bench timeout");
  end

  initial begin
    int hs0;
    #3;
    chk(trig == 0, "rst_trig", trig, 0);
    chk(meas_valid == 0, "rst_valid", meas_valid, 0);
    chk(meas_id == 0, "rst_id", meas_id, 0);
    chk(meas_width == 0, "rst_width", meas_width, 0);
    chk(meas_timeout == 0, "rst_timeout", meas_timeout, 0);
    chk(busy == 0, "rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    en = 1'b1;

    for (int i = 0; i < 20000 && n_hs < 5; i++) @(negedge clk);
    chk(n_hs >= 5, "progress_a", n_hs, 5);
    stall_req = 1'b1;
    for (int i = 0; i < 40000 && n_hs < 28; i++) @(negedge clk);
    chk(n_hs >= 28, "progress_b", n_hs, 28);

    // Drop en while sensor 3 is measuring; its result must still arrive.
    for (int i = 0; i < 3000 && !trig[3]; i++) @(negedge clk);
    chk(trig[3], "reach_sensor3", trig, 8);
    force_hit = 1'b1;
    hs0 = n_hs;
    for (int i = 0; i < 100 && trig != 0; i++) @(negedge clk);
    repeat (20) @(posedge clk);
    #1 en = 1'b0;
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
    chk(!busy, "idle_after_en_drop", busy, 0);
    chk(n_hs == hs0 + 1, "en_drop_reported", n_hs, hs0 + 1);
    chk(sb.size() == 0, "sb_empty_idle", sb.size(), 0);
    repeat (50) @(negedge clk);
    chk(!busy && trig == 0, "stay_idle", {busy, trig}, 0);
    en = 1'b1;
    for (int i = 0; i < 10 && trig == 0; i++) @(negedge clk);
    chk(trig == 4'b0001, "resume_sensor0", trig, 1);

    // Asynchronous reset in the fourth trigger cycle of a later pulse.
    for (int i = 0; i < 3000 && trig != 0; i++) @(negedge clk);
    for (int i = 0; i < 3000 && trig == 0; i++) @(negedge clk);
    chk(trig != 0, "reach_trig", trig, 1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk(trig == 0, "async_rst_trig", trig, 0);
    chk(meas_valid == 0, "async_rst_valid", meas_valid, 0);
    chk(busy == 0, "async_rst_busy", busy, 0);
    chk(meas_id == 0, "async_rst_id", meas_id, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10 && trig == 0; i++) @(negedge clk);
    chk(trig == 4'b0001, "post_rst_sensor0", trig, 1);
    hs0 = n_hs;
    for (int i = 0; i < 3000 && n_hs < hs0 + 2; i++) @(negedge clk);
    chk(n_hs >= hs0 + 2, "post_rst_results", n_hs, hs0 + 2);
    en = 1'b0;
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
    chk(!busy, "final_idle", busy, 0);
    chk(sb.size() == 0, "final_sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
